// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: shares one 4-stage pipelined signed multiplier between
// NUM_REQ requesters. Round-robin grant, one operand pair per cycle, with a
// requester-ID tag shifted alongside the multiplier pipeline so each product
// returns with the index of its issuer. The whole pipeline (multiplier via
// mul_ce, plus the tag register) freezes while a result is held un-consumed.
// Optional build macro: MUL_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) and removes the round-robin pointer.
module mul_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = ($clog2(NUM_REQ) < 1) ? 1 : $clog2(NUM_REQ),
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DATA_W  = 12
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      mul_ce,
    output logic [DATA_W-1:0]         mul_din0,
    output logic [DATA_W-1:0]         mul_din1,
    input  logic [DATA_W-1:0]         mul_dout,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ID_W-1:0]           res_id,
    output logic [DATA_W-1:0]         res_data,
    output logic                      busy
);

    logic [LATENCY-1:0]           vld_q, vld_d;
    logic [LATENCY-1:0][ID_W-1:0] tag_q, tag_d;
    logic [NUM_REQ-1:0]           gnt;
    logic [ID_W-1:0]              gnt_idx;
    logic                         gnt_any;

`ifndef MUL_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]              ptr_q, ptr_d;
`endif

    assign res_valid = vld_q[LATENCY-1];
    assign res_id    = tag_q[LATENCY-1];
    assign res_data  = mul_dout;
    assign busy      = |vld_q;
    assign mul_ce    = !(res_valid && !res_ready);
    assign req_ready = gnt;

    // Grant search: one requester per enabled cycle, none while stalled or in reset.
    always_comb begin
        int unsigned cand;
        cand    = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        if (mul_ce && reset_n) begin
`ifdef MUL_ARB_FIXED_PRIO_EN
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!gnt_any && req_valid[k]) begin
                    gnt_any = 1'b1;
                    gnt_idx = ID_W'(k);
                end
            end
`else
            // Scan pointer+1 .. pointer+NUM_REQ; the last candidate is the
            // pointer itself, so a lone requester is granted every cycle.
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                cand = 32'(ptr_q) + k;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                if (!gnt_any && req_valid[cand[ID_W-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand[ID_W-1:0];
                end
            end
`endif
            if (gnt_any) begin
                gnt[gnt_idx] = 1'b1;
            end
        end
    end

    // Operand mux to the multiplier; zeros when a bubble is issued.
    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                mul_din0 = req_a[k*DATA_W +: DATA_W];
                mul_din1 = req_b[k*DATA_W +: DATA_W];
            end
        end
    end

    // Tag/valid pipeline next state: shift only when the multiplier advances.
    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        if (mul_ce) begin
            vld_d = {vld_q[LATENCY-2:0], gnt_any};
            tag_d = {tag_q[LATENCY-2:0], gnt_idx};
        end
    end

    // Tag/valid pipeline registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
        end
    end

`ifndef MUL_ARB_FIXED_PRIO_EN
    // Pointer next state: follows the last accepted requester.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = gnt_idx;
        end
    end

    // Round-robin pointer; resets to the top index so requester 0 goes first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= ID_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: directed vectors with hand-computed products,
// a scoreboard queue filled at grant time and drained by a result monitor.
module tb_mul_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 12;
    localparam int ID_W    = 2;

    logic                      clk;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic                      mul_ce;
    logic [DATA_W-1:0]         mul_din0;
    logic [DATA_W-1:0]         mul_din1;
    logic [DATA_W-1:0]         mul_dout;
    logic                      res_valid;
    logic                      res_ready;
    logic [ID_W-1:0]           res_id;
    logic [DATA_W-1:0]         res_data;
    logic                      busy;

    mul_share_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W),
        .LATENCY(4),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .mul_ce   (mul_ce),
        .mul_din0 (mul_din0),
        .mul_din1 (mul_din1),
        .mul_dout (mul_dout),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_id   (res_id),
        .res_data (res_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared multiplier: 4 ce-gated stages, truncated product.
    logic [DATA_W-1:0] mp [4];
    logic signed [2*DATA_W-1:0] full_prod;
    assign full_prod = $signed(mul_din0) * $signed(mul_din1);
    assign mul_dout  = mp[3];
    initial for (int i = 0; i < 4; i++) mp[i] = '0;
    always @(posedge clk) begin
        if (mul_ce) begin
            mp[0] <= full_prod[DATA_W-1:0];
            mp[1] <= mp[0];
            mp[2] <= mp[1];
            mp[3] <= mp[2];
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } exp_t;
    exp_t sbq[$];

    // Per-requester operands and their hand-computed 12-bit products.
    logic [DATA_W-1:0] a_tab [4] = '{12'h007, 12'hFF8, 12'h7FF, 12'h800};
    logic [DATA_W-1:0] b_tab [4] = '{12'h009, 12'h00B, 12'h002, 12'h002};
    logic [DATA_W-1:0] p_tab [4] = '{12'h03F, 12'hFA8, 12'hFFE, 12'h000};

`ifdef MUL_ARB_FIXED_PRIO_EN
    int g3 [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int g5 [3] = '{0, 0, 0};
    int g6 [6] = '{0, 0, 0, 0, 0, 0};
`else
    int g3 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int g5 [3] = '{2, 0, 1};
    int g6 [6] = '{0, 2, 0, 2, 0, 2};
`endif

    task automatic set_op(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        req_a[i*DATA_W +: DATA_W] = a;
        req_b[i*DATA_W +: DATA_W] = b;
    endtask

    task automatic expect_grant(input int id, input logic [DATA_W-1:0] prod);
        exp_t e;
        chk("req_ready", 32'(req_ready), 32'(1 << id));
        e.id   = id[ID_W-1:0];
        e.data = prod;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Result monitor: every consumed result must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && res_valid && res_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_result", {30'd0, res_id}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("res_id", 32'(res_id), 32'(e.id));
                chk("res_data", 32'(res_data), 32'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        set_op(0, 12'h003, 12'hFFB);
        req_valid = 4'b0001;

        // Reset state: nothing accepted, nothing valid.
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Test 1: 3 * -5 = -15 -> 0xFF1, result 4 cycles after accept.
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        expect_grant(0, 12'hFF1);
        chk("t1_din0", 32'(mul_din0), 32'h003);
        chk("t1_din1", 32'(mul_din1), 32'hFFB);
        @(posedge clk);
        #1 req_valid = '0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("t1_busy", 32'(busy), 32'h1);
            chk("t1_res_valid", 32'(res_valid), (c == 4) ? 32'h1 : 32'h0);
            if (c == 1) chk("t1_bubble_din0", 32'(mul_din0), 32'h0);
        end
        @(negedge clk);
        chk("t1_busy_after", 32'(busy), 32'h0);
        chk("t1_res_valid_after", 32'(res_valid), 32'h0);

        // Test 2: 100 * 100 = 10000 -> low 12 bits 0x710.
        @(posedge clk);
        #1 set_op(1, 12'd100, 12'd100);
        req_valid = 4'b0010;
        @(negedge clk);
        expect_grant(1, 12'h710);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (6) @(posedge clk);
        #1;

        // Test 3: all requesters valid for 8 cycles, back-to-back results.
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, a_tab[i], b_tab[i]);
        req_valid = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k < 8) expect_grant(g3[k], p_tab[g3[k]]);
            else chk("t3_idle_ready", 32'(req_ready), 32'h0);
            chk("t3_res_valid", 32'(res_valid), (k >= 4) ? 32'h1 : 32'h0);
            @(posedge clk);
            #1;
            if (k == 7) req_valid = '0;
        end
        @(negedge clk);
        chk("t3_res_valid_end", 32'(res_valid), 32'h0);
        chk("t3_busy_end", 32'(busy), 32'h0);

        // Test 4: two results in flight, consumer stalls 5 cycles.
        @(posedge clk);
        #1 set_op(0, 12'd5, 12'd6);
        req_valid = 4'b0001;
        @(negedge clk);
        expect_grant(0, 12'h01E);
        @(posedge clk);
        #1 set_op(1, 12'hFFD, 12'hFFC);
        req_valid = 4'b0010;
        @(negedge clk);
        expect_grant(1, 12'h00C);
        @(posedge clk);
        #1 req_valid = '0;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 4'b0100;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("t4_mul_ce", 32'(mul_ce), 32'h0);
            chk("t4_req_ready", 32'(req_ready), 32'h0);
            chk("t4_res_valid", 32'(res_valid), 32'h1);
            chk("t4_res_id", 32'(res_id), 32'h0);
            chk("t4_res_data", 32'(res_data), 32'h01E);
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        chk("t4_rel_valid0", 32'(res_valid), 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t4_rel_valid1", 32'(res_valid), 32'h1);
        chk("t4_rel_id1", 32'(res_id), 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t4_drained", 32'(res_valid), 32'h0);
        chk("t4_busy", 32'(busy), 32'h0);

        // Test 5: reset while three entries are in flight.
        @(posedge clk);
        #1 for (int i = 0; i < 4; i++) set_op(i, a_tab[i], b_tab[i]);
        req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_grant", 32'(req_ready), 32'(1 << g5[k]));
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        @(posedge clk);
        #1 chk("t5_pre_res_valid", 32'(res_valid), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_res_valid", 32'(res_valid), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        expect_grant(0, p_tab[0]);
        chk("t5_no_stale0", 32'(res_valid), 32'h0);
        @(posedge clk);
        #1 req_valid = '0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("t5_no_stale", 32'(res_valid), 32'h0);
        end
        @(negedge clk);
        chk("t5_first_result", 32'(res_valid), 32'h1);
        repeat (3) @(posedge clk);
        #1;

        // Test 6: requesters 0 and 2 continuously valid.
        do_reset();
        req_valid = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            expect_grant(g6[k], p_tab[g6[k]]);
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'h0);
        chk("final_busy", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one pipelined 12-bit signed multiplier (4 ce-gated register stages, truncated 12-bit product) between NUM_REQ requesters.
- Round-robin arbitration issues at most one operand pair per cycle.
- A requester-ID tag travels in lockstep with the multiplier pipeline, so each result returns with the ID of its issuer.
- Sits between the MLP layer sequencers and the shared multiplier instance; drives the multiplier's ce.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, result tag width, = max(1, clog2(NUM_REQ))
LATENCY, 4, multiplier ce-enabled stages from operand capture to dout
DATA_W, 12, operand/result width (signed)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operand pair valid
req_ready  out  NUM_REQ  per-requester grant/accept (one-hot or zero)
req_a  in  NUM_REQ*DATA_W  packed operand A, requester i at [i*DATA_W +: DATA_W]
req_b  in  NUM_REQ*DATA_W  packed operand B, same packing
mul_ce  out  1  multiplier clock enable
mul_din0  out  DATA_W  operand A to multiplier
mul_din1  out  DATA_W  operand B to multiplier
mul_dout  in  DATA_W  multiplier product
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_id  out  ID_W  requester index of current result
res_data  out  DATA_W  product, equal to mul_dout
busy  out  1  any valid entry in flight

Behaviour:
- Reset (async assert, sync release): tag/valid shift register cleared; res_valid=0, busy=0, req_ready=0; RR pointer = NUM_REQ-1, so requester 0 has first priority.
- Stall: mul_ce = !(res_valid && !res_ready), combinational. When mul_ce=0 the whole pipeline (multiplier and tag register) freezes and req_ready=0.
- Grant (mul_ce=1): search from pointer+1 upward, wrapping modulo NUM_REQ. First i with req_valid[i] gets req_ready[i]=1.
  - req_ready is combinational from req_valid and pointer.
  - Requesters must not make req_valid depend on req_ready, and must hold req_a/req_b stable until accepted.
- Accept: req_valid[i] && req_ready[i].
  - mul_din0/din1 = req_a[i]/req_b[i] in that cycle.
  - Valid bit 1 and tag i enter stage 0 of the shift register.
  - Pointer <= i on the same edge.
- No grant with mul_ce=1: a bubble (valid 0) enters the shift register. mul_din0/din1 = 0. Pointer unchanged.
- Shift register has LATENCY stages and advances only on mul_ce=1.
  - res_valid = stage[LATENCY-1].valid; res_id = stage[LATENCY-1].tag; res_data = mul_dout.
  - An operand accepted at ce-edge k appears as a result after LATENCY further ce-enabled edges. With no stalls: accept in cycle t, res_valid in cycle t+LATENCY.
- Throughput: one result per cycle sustained when res_ready=1.
- Result held stable while res_valid && !res_ready. Drops on the edge after res_ready=1 unless the next stage is valid.
- Arithmetic: res_data is the low 12 bits of the signed product (wrap, no saturation). The arbiter performs no arithmetic.
- busy = OR of all stage valid bits.
- Reset mid-operation: all in-flight entries are discarded. Multiplier contents are undefined afterwards, but masked because every valid bit is 0. No stale result is ever flagged valid.
- Single requester continuously valid: granted every cycle (pointer wraps back to itself).
- NUM_REQ not a power of 2: pointer wraps at NUM_REQ-1 to 0; unused tag codes never produced.

Optional Feature:
MUL_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins every cycle. Pointer register removed; reset of pointer not applicable.
- Undefined (default): round-robin as above.

Test Plan:
1. Req0 only, a=3, b=-5, res_ready=1 -> req_ready[0]=1 in cycle t; res_valid=1 in t+4 with res_id=0, res_data=12'hFF1 (-15); busy high t+1..t+4.
2. Req1 a=100, b=100 -> res_data=12'h710 (10000 truncated); no saturation.
3. Req0..3 all continuously valid, distinct operands, res_ready=1 -> grants 0,1,2,3,0,1... one per cycle; results in same order with matching ids and products, no gaps.
4. Two results in flight, res_ready=0 for 5 cycles -> mul_ce=0, req_ready=0, res_valid/res_id/res_data stable. After release, second result follows on the next cycle, none lost or duplicated.
5. Issue 3 requests, assert reset_n=0 for one cycle mid-flight -> res_valid=0 and busy=0 immediately. No res_valid for 4 cycles after release; first grant goes to requester 0.
6. With MUL_ARB_FIXED_PRIO_EN, req0 and req2 continuously valid -> req0 granted every cycle, req2 never. Without the macro -> grants alternate 0,2,0,2.
